buf_ctrl0_wr_ctrl: RTL and testbench

//  Write-side controller feeding the BUF_CTRL0 dual-port buffer RAM.
//  - Accepts a valid/ready input stream and produces WADD/WDT/WEN for the RAM write port.
//  - Treats the RAM as two ping-pong banks and tells the read side when a bank is complete.
//  - Frees a bank again on a release pulse from the read side (already synchronised to CLK).

---
 rtl/buf_ctrl0_pkg.sv | 23 ++
 rtl/buf_ctrl0_wr_ctrl_if.sv | 44 ++++
 rtl/buf_ctrl0_bank_state.sv | 36 +++
 rtl/buf_ctrl0_wr_ctrl.sv | 139 +++++++++++++
 tb/tb_buf_ctrl0_wr_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/buf_ctrl0_pkg.sv
// Shared types and helpers for the BUF_CTRL0 write-side controller.
// Optional feature macro used by the block: BUF_CTRL0_WR_LAST_EN.
package buf_ctrl0_pkg;

   localparam int NUM_BANKS = 2;

   typedef enum logic [1:0] {
      BANK_FREE = 2'd0,
      BANK_FILL = 2'd1,
      BANK_FULL = 2'd2
   } bank_state_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } wr_state_e;

   // Width that can hold a bank length from 0 up to and including bank_words.
   function automatic int calc_lw(input int bank_words);
      return $clog2(bank_words) + 1;
   endfunction

endpackage

// File: rtl/buf_ctrl0_wr_ctrl_if.sv
// Stream, RAM write port and bank handshake of the BUF_CTRL0 write controller.
// i_s_last exists only when BUF_CTRL0_WR_LAST_EN is defined.
interface buf_ctrl0_wr_ctrl_if #(
   parameter int P_DBUS_W     = 32,
   parameter int P_ABUS_W     = 12,
   parameter int P_BANK_WORDS = 2048
);
   import buf_ctrl0_pkg::*;

   localparam int LW = calc_lw(P_BANK_WORDS);

   logic                i_s_valid;
   logic [P_DBUS_W-1:0] i_s_data;
`ifdef BUF_CTRL0_WR_LAST_EN
   logic                i_s_last;
`endif
   logic                o_s_ready;
   logic [P_ABUS_W-1:0] o_wadd;
   logic [P_DBUS_W-1:0] o_wdt;
   logic                o_wen;
   logic                o_bank_rdy;
   logic                o_bank_id;
   logic [LW-1:0]       o_bank_len;
   logic                i_bank_rel;
   logic                i_bank_rel_id;
   logic                o_rel_err;

   modport slave (
      input  i_s_valid, i_s_data, i_bank_rel, i_bank_rel_id,
`ifdef BUF_CTRL0_WR_LAST_EN
      input  i_s_last,
`endif
      output o_s_ready, o_wadd, o_wdt, o_wen, o_bank_rdy, o_bank_id, o_bank_len, o_rel_err
   );

   modport master (
      output i_s_valid, i_s_data, i_bank_rel, i_bank_rel_id,
`ifdef BUF_CTRL0_WR_LAST_EN
      output i_s_last,
`endif
      input  o_s_ready, o_wadd, o_wdt, o_wen, o_bank_rdy, o_bank_id, o_bank_len, o_rel_err
   );

endinterface

// File: rtl/buf_ctrl0_bank_state.sv
// State of one ping-pong bank: FREE -> FILL -> FULL -> FREE, plus release checking.
module buf_ctrl0_bank_state
   import buf_ctrl0_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_start,   // writer begins filling this bank
   input  logic i_close,   // last word of this bank accepted
   input  logic i_rel,     // read side releases this bank
   output logic o_avail,   // free now, or becoming free this cycle
   output logic o_err      // release hit a bank that is not FULL
);

   bank_state_e r_state;
   bank_state_e w_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= BANK_FREE;
      else     r_state <= w_next;
   end

   // NOTE: the next state defaults to the current state before the case so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         BANK_FREE: if (i_start) w_next = BANK_FILL;
         BANK_FILL: if (i_close) w_next = BANK_FULL;
         BANK_FULL: if (i_rel)   w_next = i_start ? BANK_FILL : BANK_FREE;
         default:                w_next = BANK_FREE;
      endcase
   end

   assign o_avail = (r_state == BANK_FREE) || (i_rel && (r_state == BANK_FULL));
   assign o_err   = i_rel && (r_state != BANK_FULL);

endmodule

// File: rtl/buf_ctrl0_wr_ctrl.sv
// Write-side controller for the BUF_CTRL0 ping-pong buffer RAM.
// Define BUF_CTRL0_WR_LAST_EN to let i_s_last close a bank early.
module buf_ctrl0_wr_ctrl
   import buf_ctrl0_pkg::*;
#(
   parameter int P_DBUS_W     = 32,
   parameter int P_ABUS_W     = 12,
   parameter int P_BANK_WORDS = 2048
) (
   input  logic                clk,
   input  logic                rst,
   buf_ctrl0_wr_ctrl_if.slave  bus
);

   localparam int LW = calc_lw(P_BANK_WORDS);
   localparam int PW = LW - 1;

   wr_state_e             r_state;
   wr_state_e             w_next_state;
   logic                  r_fill_bank;
   logic [PW-1:0]         r_ptr;
   logic                  r_s_ready;
   logic                  r_wen;
   logic [P_ABUS_W-1:0]   r_wadd;
   logic [P_DBUS_W-1:0]   r_wdt;
   logic                  r_close_d;
   logic                  r_close_id;
   logic [LW-1:0]         r_close_len;
   logic                  r_bank_rdy;
   logic                  r_bank_id;
   logic [LW-1:0]         r_bank_len;
   logic                  r_rel_err;

   logic                  w_accept;
   logic                  w_last;
   logic                  w_close;
   logic                  w_target;
   logic [P_ABUS_W-1:0]   w_wadd;
   logic [NUM_BANKS-1:0]  w_start;
   logic [NUM_BANKS-1:0]  w_rel;
   logic [NUM_BANKS-1:0]  w_avail;
   logic [NUM_BANKS-1:0]  w_err;

`ifdef BUF_CTRL0_WR_LAST_EN
   assign w_last = bus.i_s_last;
`else
   assign w_last = 1'b0;
`endif

   assign w_accept = bus.i_s_valid & r_s_ready;
   assign w_close  = w_accept & (w_last | (r_ptr == PW'(P_BANK_WORDS - 1)));
   assign w_wadd   = (r_fill_bank ? P_ABUS_W'(P_BANK_WORDS) : '0) + P_ABUS_W'(r_ptr);

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++)
         w_rel[b] = bus.i_bank_rel && (bus.i_bank_rel_id == 1'(b));
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      buf_ctrl0_bank_state u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_start (w_start[g]),
         .i_close (w_close && (r_fill_bank == 1'(g))),
         .i_rel   (w_rel[g]),
         .o_avail (w_avail[g]),
         .o_err   (w_err[g])
      );
   end

   // On a close the FSM looks at the other bank, which counts as free if released this cycle.
   always_comb begin
      w_next_state = r_state;
      w_target     = r_fill_bank;
      w_start      = '0;
      case (r_state)
         ST_IDLE: if (w_avail[r_fill_bank]) w_next_state = ST_FILL;
         ST_FILL: if (w_close) begin
            w_target     = ~r_fill_bank;
            w_next_state = w_avail[w_target] ? ST_FILL : ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
      if ((w_next_state == ST_FILL) && ((r_state == ST_IDLE) || w_close))
         w_start[w_target] = 1'b1;
   end

   // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_fill_bank <= 1'b0;
         r_ptr       <= '0;
         r_s_ready   <= 1'b0;
         r_wen       <= 1'b0;
         r_wadd      <= '0;
         r_wdt       <= '0;
         r_close_d   <= 1'b0;
         r_close_id  <= 1'b0;
         r_close_len <= '0;
         r_bank_rdy  <= 1'b0;
         r_bank_id   <= 1'b0;
         r_bank_len  <= '0;
         r_rel_err   <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_s_ready <= (w_next_state == ST_FILL);
         r_wen     <= w_accept;
         if (w_accept) begin
            r_wadd <= w_wadd;
            r_wdt  <= bus.i_s_data;
            r_ptr  <= w_close ? '0 : r_ptr + 1'b1;
         end
         if (w_close) begin
            r_fill_bank <= ~r_fill_bank;
            r_close_id  <= r_fill_bank;
            r_close_len <= LW'(r_ptr) + 1'b1;
         end
         // BANK_RDY trails the last WEN by one cycle so the RAM write has landed.
         r_close_d  <= w_close;
         r_bank_rdy <= r_close_d;
         if (r_close_d) begin
            r_bank_id  <= r_close_id;
            r_bank_len <= r_close_len;
         end
         if (|w_err) r_rel_err <= 1'b1;
      end
   end

   assign bus.o_s_ready  = r_s_ready;
   assign bus.o_wen      = r_wen;
   assign bus.o_wadd     = r_wadd;
   assign bus.o_wdt      = r_wdt;
   assign bus.o_bank_rdy = r_bank_rdy;
   assign bus.o_bank_id  = r_bank_id;
   assign bus.o_bank_len = r_bank_len;
   assign bus.o_rel_err  = r_rel_err;

endmodule

// File: tb/tb_buf_ctrl0_wr_ctrl.sv
// Directed bench for buf_ctrl0_wr_ctrl with 8-word banks; the S_LAST steps run when
// BUF_CTRL0_WR_LAST_EN is defined.
module tb_buf_ctrl0_wr_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   buf_ctrl0_wr_ctrl_if #(.P_DBUS_W(32), .P_ABUS_W(4), .P_BANK_WORDS(8)) bus ();

   buf_ctrl0_wr_ctrl #(.P_DBUS_W(32), .P_ABUS_W(4), .P_BANK_WORDS(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // NOTE: outputs are sampled 1 time unit after the rising edge, inputs driven with blocking writes.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_s_ready"},  64'(bus.o_s_ready),  64'd0);
      check({tag, "_wadd"},     64'(bus.o_wadd),     64'd0);
      check({tag, "_wdt"},      64'(bus.o_wdt),      64'd0);
      check({tag, "_wen"},      64'(bus.o_wen),      64'd0);
      check({tag, "_bank_rdy"}, 64'(bus.o_bank_rdy), 64'd0);
      check({tag, "_bank_id"},  64'(bus.o_bank_id),  64'd0);
      check({tag, "_bank_len"}, 64'(bus.o_bank_len), 64'd0);
      check({tag, "_rel_err"},  64'(bus.o_rel_err),  64'd0);
   endtask

   // Offer one beat (s_ready is known to be 1) and check it on the write port next cycle.
   task automatic beat(input logic [31:0] d, input logic [3:0] a, input logic rdy);
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = d;
      cyc();
      check($sformatf("b%0d_wen", d),  64'(bus.o_wen),      64'd1);
      check($sformatf("b%0d_wadd", d), 64'(bus.o_wadd),     64'(a));
      check($sformatf("b%0d_wdt", d),  64'(bus.o_wdt),      64'(d));
      check($sformatf("b%0d_rdy", d),  64'(bus.o_bank_rdy), 64'(rdy));
   endtask

   initial begin
      rst               = 1'b1;
      bus.i_s_valid     = 1'b0;
      bus.i_s_data      = '0;
      bus.i_bank_rel    = 1'b0;
      bus.i_bank_rel_id = 1'b0;
`ifdef BUF_CTRL0_WR_LAST_EN
      bus.i_s_last      = 1'b0;
`endif
      cyc();
      cyc();
      check_reset("por");
      rst = 1'b0;
      check("exit_s_ready_low", 64'(bus.o_s_ready), 64'd0);
      cyc();
      check("exit_s_ready", 64'(bus.o_s_ready), 64'd1);

      // 1: bank 0 filled with 0..7, other bank free so s_ready holds
      for (int i = 0; i < 8; i++) beat(32'(i), 4'(i), 1'b0);
      check("t1_s_ready", 64'(bus.o_s_ready), 64'd1);

      // 2: bank 1 filled with 8..15, BANK_RDY for bank 0 one cycle after its last WEN
      beat(32'd8, 4'd8, 1'b1);
      check("t1_bank_id",  64'(bus.o_bank_id),  64'd0);
      check("t1_bank_len", 64'(bus.o_bank_len), 64'd8);
      for (int i = 9; i < 16; i++) beat(32'(i), 4'(i), 1'b0);
      check("t2_s_ready_drop", 64'(bus.o_s_ready), 64'd0);
      bus.i_s_data = 32'd99;
      cyc();
      check("t2_no_wen",   64'(bus.o_wen),      64'd0);
      check("t2_rdy",      64'(bus.o_bank_rdy), 64'd1);
      check("t2_bank_id",  64'(bus.o_bank_id),  64'd1);
      check("t2_bank_len", 64'(bus.o_bank_len), 64'd8);
      check("t2_s_ready",  64'(bus.o_s_ready),  64'd0);
      cyc();
      check("t2_idle_wen", 64'(bus.o_wen),      64'd0);
      check("t2_idle_rdy", 64'(bus.o_bank_rdy), 64'd0);
      bus.i_s_valid     = 1'b0;
      bus.i_bank_rel    = 1'b1;
      bus.i_bank_rel_id = 1'b0;
      cyc();
      bus.i_bank_rel = 1'b0;
      check("t2_rel_s_ready", 64'(bus.o_s_ready), 64'd1);
      check("t2_rel_err",     64'(bus.o_rel_err), 64'd0);
      beat(32'd16, 4'd0, 1'b0);

      // 3: bank 1 released in the cycle bank 0 closes -> no ready gap
      for (int i = 17; i < 23; i++) beat(32'(i), 4'(i - 16), 1'b0);
      bus.i_bank_rel    = 1'b1;
      bus.i_bank_rel_id = 1'b1;
      beat(32'd23, 4'd7, 1'b0);
      bus.i_bank_rel = 1'b0;
      check("t3_s_ready", 64'(bus.o_s_ready), 64'd1);
      beat(32'd24, 4'd8, 1'b1);
      check("t3_bank_id",  64'(bus.o_bank_id),  64'd0);
      check("t3_bank_len", 64'(bus.o_bank_len), 64'd8);
      check("t3_rel_err",  64'(bus.o_rel_err),  64'd0);

      // 5: reset drops the in-flight WEN, then a partial bank 0 is discarded by a second reset
      rst = 1'b1;
      #1;
      check_reset("r1");
      cyc();
      rst = 1'b0;
      cyc();
      check("r1_s_ready", 64'(bus.o_s_ready), 64'd1);
      check("r1_wen",     64'(bus.o_wen),     64'd0);
      for (int i = 0; i < 3; i++) beat(32'(30 + i), 4'(i), 1'b0);
      rst = 1'b1;
      #1;
      check_reset("r2");
      cyc();
      check("r2_hold_rdy", 64'(bus.o_bank_rdy), 64'd0);
      cyc();
      rst = 1'b0;
      cyc();
      check("r2_no_rdy",  64'(bus.o_bank_rdy), 64'd0);
      check("r2_s_ready", 64'(bus.o_s_ready),  64'd1);

      // 4: releasing free bank 1 flags REL_ERR and leaves both banks alone
      beat(32'd40, 4'd0, 1'b0);
      bus.i_bank_rel    = 1'b1;
      bus.i_bank_rel_id = 1'b1;
      beat(32'd41, 4'd1, 1'b0);
      bus.i_bank_rel = 1'b0;
      check("t4_rel_err", 64'(bus.o_rel_err), 64'd1);
      for (int i = 42; i < 48; i++) beat(32'(i), 4'(i - 40), 1'b0);
      check("t4_s_ready", 64'(bus.o_s_ready), 64'd1);
      beat(32'd48, 4'd8, 1'b1);
      check("t4_bank_len",     64'(bus.o_bank_len), 64'd8);
      check("t4_rel_err_held", 64'(bus.o_rel_err),  64'd1);

      rst = 1'b1;
      #1;
      check_reset("r3");
      cyc();
      rst = 1'b0;
      bus.i_s_valid = 1'b0;
      cyc();
      check("r3_s_ready", 64'(bus.o_s_ready), 64'd1);

`ifdef BUF_CTRL0_WR_LAST_EN
      // 6: early close on the 3rd beat, then S_LAST on a bank's final word closes it once
      beat(32'd80, 4'd0, 1'b0);
      beat(32'd81, 4'd1, 1'b0);
      bus.i_s_last = 1'b1;
      beat(32'd82, 4'd2, 1'b0);
      bus.i_s_last = 1'b0;
      check("t6_s_ready", 64'(bus.o_s_ready), 64'd1);
      beat(32'd83, 4'd8, 1'b1);
      check("t6_bank_id",  64'(bus.o_bank_id),  64'd0);
      check("t6_bank_len", 64'(bus.o_bank_len), 64'd3);
      for (int i = 84; i < 90; i++) beat(32'(i), 4'(i - 75), 1'b0);
      bus.i_s_last = 1'b1;
      beat(32'd90, 4'd15, 1'b0);
      bus.i_s_last  = 1'b0;
      bus.i_s_valid = 1'b0;
      check("t6_s_ready_drop", 64'(bus.o_s_ready), 64'd0);
      cyc();
      check("t6_rdy",       64'(bus.o_bank_rdy), 64'd1);
      check("t6_bank_id1",  64'(bus.o_bank_id),  64'd1);
      check("t6_bank_len8", 64'(bus.o_bank_len), 64'd8);
      check("t6_wen",       64'(bus.o_wen),      64'd0);
      cyc();
      check("t6_single_rdy", 64'(bus.o_bank_rdy), 64'd0);
`endif

      bus.i_s_valid = 1'b0;
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of run, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
